// File: rtl/led_pkg.sv
// Shared types and helpers for the LED bank arbiter: state encoding, idle scan
// pattern and the round-robin picker.
package led_pkg;

    localparam int unsigned LED_W   = 16;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic [0:0] {StIdle, StHold} state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    // Single lit LED: sweeps up for phase[4]=0, back down for phase[4]=1.
    function automatic logic [LED_W-1:0] idle_pattern(input logic [4:0] phase);
        return phase[4] ? (16'h8000 >> phase[3:0]) : (16'h0001 << phase[3:0]);
    endfunction

    // First set request after 'last', wrapping modulo n (n <= MAX_REQ).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [2:0] last,
                                      input int unsigned n);
        pick_t       res;
        int unsigned k;
        logic [2:0]  kk;
        res = '0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            k  = (32'(last) + i) % n;
            kk = 3'(k);
            if (i <= n && !res.valid && req[kk]) begin
                res.valid = 1'b1;
                res.idx   = kk;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler; TICK is high for the one cycle the counter is all-ones.
module led_tick_gen #(
    parameter int unsigned TICKBITS = 24
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    logic [TICKBITS-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TICKBITS'(1);
        end
    end

    assign TICK = &cnt_q;

endmodule

// File: rtl/led_display_arbiter.sv
// Round-robin arbiter sharing the 16-LED bank between NREQ requesters, with a
// minimum dwell per grant and an idle sweep when nobody is requesting.
module led_display_arbiter
    import led_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TICKBITS = 24,
    parameter int unsigned DWELL    = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       REQ,
    input  logic [LED_W*NREQ-1:0] PAT,
    output logic [NREQ-1:0]       GNT,
    output logic [LED_W-1:0]      LD,
    output logic                  TICK
);

    localparam logic [7:0] DWELL_V = 8'(DWELL);

    state_t                          state_q, state_d;
    logic [4:0]                      phase_q, phase_d;
    logic [7:0]                      dwell_q, dwell_d;
    logic [2:0]                      last_q, last_d;
    logic [NREQ-1:0]                 gnt_q, gnt_d;
    logic [LED_W-1:0]                ld_q, ld_d;

    logic [MAX_REQ-1:0]              req_ext;
    logic [MAX_REQ-1:0][LED_W-1:0]   pats;
    logic [MAX_REQ-1:0]              pick_oh;
    pick_t                           pick;
    logic                            rel;

    led_tick_gen #(
        .TICKBITS (TICKBITS)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (TICK)
    );

    // Widen to MAX_REQ so a 3-bit index is always in range.
    always_comb begin
        req_ext = '0;
        pats    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_ext[i] = REQ[i];
            pats[i]    = PAT[LED_W*i +: LED_W];
        end
    end

    assign pick    = rr_pick(req_ext, last_q, NREQ);
    assign pick_oh = MAX_REQ'(1) << pick.idx;
    // A drop coinciding with expiry is still a single release.
    assign rel     = !req_ext[last_q] || (TICK && dwell_q == 8'd1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        ld_d    = ld_q;
        phase_d = TICK ? phase_q + 5'd1 : phase_q;

        unique case (state_q)
            StIdle: begin
                if (pick.valid) begin
                    state_d = StHold;
                    gnt_d   = pick_oh[NREQ-1:0];
                    last_d  = pick.idx;
                    dwell_d = DWELL_V;
                    ld_d    = pats[pick.idx];
                end else begin
                    ld_d = idle_pattern(phase_d);
                end
            end
            StHold: begin
                if (rel) begin
                    if (pick.valid) begin
                        gnt_d   = pick_oh[NREQ-1:0];
                        last_d  = pick.idx;
                        dwell_d = DWELL_V;
                        ld_d    = pats[pick.idx];
                    end else begin
                        state_d = StIdle;
                        gnt_d   = '0;
                        ld_d    = idle_pattern(phase_d);
                    end
                end else begin
                    ld_d = pats[last_q];
                    if (TICK) begin
                        dwell_d = dwell_q - 8'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            phase_q <= '0;
            dwell_q <= '0;
            last_q  <= 3'(NREQ - 1);
            gnt_q   <= '0;
            ld_q    <= 16'h0001;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dwell_q <= dwell_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            ld_q    <= ld_d;
        end
    end

    assign GNT = gnt_q;
    assign LD  = ld_q;

endmodule

// File: doc/led_display_arbiter.md
Name: led_display_arbiter

Overview:
- Shares the board's 16-LED bank between NREQ requesters.
- Each requester presents a 16-bit pattern and a request; the block grants one requester at a time, round-robin, for a minimum dwell measured in prescaler ticks.
- With no requests pending, it drives an internally generated idle scan: a single lit LED sweeping left, then right.
- Sits between application logic and the LD output buffers in the top level.

Parameters:
- NREQ, 4, number of requesters, 2..8.
- TICKBITS, 24, prescaler width; one tick every 2^TICKBITS CLK cycles.
- DWELL, 4, grant hold time in ticks, 1..255.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  NREQ  per-requester display request, level-sensitive.
- PAT  input  16*NREQ  requester i pattern in PAT[16*i+15:16*i].
- GNT  output  NREQ  registered one-hot grant; all-zero when idle.
- LD  output  16  registered LED drive.
- TICK  output  1  one-cycle prescaler pulse, for debug/cascade.

Behaviour:
- Reset (RST=1 at an edge) gives: prescaler=0, phase=0, state=IDLE, GNT=0, LD=16'h0001, dwell=0, last=NREQ-1 (so the first grant searches from requester 0). RST has priority over all other events.
- Prescaler:
  - TICKBITS-bit counter, +1 every cycle, wraps.
  - TICK is combinational: high while the counter is all-ones.
- Idle phase:
  - 5-bit counter, +1 on every TICK in both states, wraps 31->0.
  - Idle pattern = phase[4] ? (16'h8000 >> phase[3:0]) : (16'h0001 << phase[3:0]).
- State IDLE:
  - Each cycle, LD <= idle pattern for the phase value after this edge's update.
  - If any REQ bit is set, choose g = first set bit searching last+1, last+2, ... modulo NREQ.
  - Next edge: state=HOLD, GNT=onehot(g), last=g, dwell=DWELL, LD=PAT[g] sampled at that edge.
  - Grant latency is 1 cycle from REQ; tick alignment does not matter.
- State HOLD, granted g:
  - LD <= PAT[g] every cycle (1-cycle latency on pattern changes).
  - On TICK: if dwell==1 the grant expires, else dwell decrements.
  - Release occurs when REQ[g]==0 (early drop) or the grant expires. A drop in the same cycle as TICK counts as a drop.
  - On release, the next edge re-arbitrates with the same round-robin rule from g+1 using the current REQ:
    - any request present: stay HOLD with the new one-hot GNT, dwell=DWELL, LD=PAT[new].
    - none: go to IDLE with GNT=0 and LD=idle pattern.
  - If only g is still requesting, g is re-granted with a fresh dwell and no gap cycle.
- GNT is never multi-hot. There is never a cycle with GNT=0 between back-to-back grants.
- REQ bits for inactive requesters are don't-care for PAT.

Decomposition:
- Shared package led_pkg:
  - LED_W=16.
  - State encoding IDLE/HOLD.
  - Function idle_pattern(phase[4:0]).
  - Function rr_pick(req, last) returning the next index and a valid flag.
- Sub-module led_tick_gen (parameter TICKBITS; ports CLK, RST, TICK) holds the prescaler.
- Arbitration FSM, dwell counter and LD register live in the top module.

Test Plan (TICKBITS=3 so TICK every 8 cycles, DWELL=2, NREQ=4):
- Reset, REQ=0:
  - LD=0x0001 and GNT=0 after reset; LD=0x0002 after the first TICK.
  - After 16 TICKs LD=0x8000; after 17 LD=0x4000; after 32 LD=0x0001.
- REQ=4'b0010 held, PAT1=0xA5A5:
  - One edge later GNT=0010 and LD=0xA5A5.
  - Change PAT1 to 0x0F0F -> LD follows one cycle later.
  - After 2 TICKs g=1 is re-granted, GNT stays 0010 with no zero cycle.
- REQ=4'b1011 held, distinct patterns:
  - Grant sequence 0,1,3,0,1, each lasting exactly 2 TICKs (16 cycles).
  - LD tracks the granted pattern.
- Granted 2 with REQ=4'b0100:
  - Deassert REQ[2] mid-dwell -> next edge GNT=0 and LD=idle pattern of the current phase.
  - Repeat with REQ[3] also set -> next edge GNT=1000.
- Drop coincident with TICK while dwell==1: exactly one release, next grant chosen from g+1.
- RST pulsed mid-HOLD (GNT=1000):
  - Next edge GNT=0 and LD=0x0001.
  - Then REQ=4'b1001 -> first grant goes to requester 0.
